supertile_frame_loader: RTL and testbench
=========================================

// Module: supertile_frame_loader
// PURPOSE
//  Parametrised configuration-frame loader for an N-row supertile (DSP and similar multi-row tiles).
//  Accepts frame words over a valid/ready stream and drives each sub-tile row's FrameData bus.
//  Pulses exactly one FrameStrobe bit per word, with setup and hold margins around the strobe.
//  Sits between the bitstream frame register and the stacked sub-tiles of one supertile column.
// PARAMETERS
//  NumRows          2   number of sub-tile rows in the supertile (>=1)
//  MaxFramesPerCol  20  frame strobes per row
//  FrameBitsPerRow  32  FrameData width per row
//  StrobeLen        1   cycles FrameStrobe is held high (>=1)
//  RowW             $clog2(NumRows) or 1 if NumRows==1   width of in_row
//  FrmW             $clog2(MaxFramesPerCol)              width of in_frame
// PORTS
//  UserCLK         in   1                          clock; all logic is rising-edge
//  Reset           in   1                          asynchronous, active-high reset
//  in_valid        in   1                          frame word valid
//  in_ready        out  1                          loader can accept a word
//  in_row          in   RowW                       target sub-tile row
//  in_frame        in   FrmW                       target frame index within the row
//  in_data         in   FrameBitsPerRow            frame data word
//  clear_err       in   1                          synchronous clear of err
//  FrameData       out  NumRows*FrameBitsPerRow    per-row data; row r = [r*FBPR +: FBPR]
//  FrameStrobe     out  NumRows*MaxFramesPerCol    per-row strobes; row r = [r*MFPC +: MFPC]
//  busy            out  1                          loader is not in IDLE
//  err             out  1                          sticky: out-of-range word dropped
//  frames_written  out  16                         count of completed frame writes
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; FrameData=0; FrameStrobe=0; err=0; frames_written=0; busy=0.
//    in_ready is 1 whenever Reset is low and state is IDLE.
//  - State machine IDLE -> SETUP -> STROBE -> HOLD -> IDLE; in_ready = (state==IDLE); busy = !in_ready.
//  - IDLE: on in_valid&&in_ready, check the word.
//      - Valid word (in_row<NumRows and in_frame<MaxFramesPerCol): latch row/frame/data, go to SETUP.
//      - Invalid word: dropped; err<=1; stay IDLE (the word is consumed).
//  - SETUP (1 cycle): FrameData row latched_row = latched data; all strobes low.
//    Other rows' FrameData keep their last value.
//  - STROBE (StrobeLen cycles, down-counter): only bit latched_frame of row latched_row is high.
//    FrameData is unchanged.
//  - HOLD (1 cycle): strobes low; FrameData unchanged.
//    frames_written += 1 on the HOLD->IDLE edge, saturating at 16'hFFFF.
//  - Latency: word accepted at cycle 0; strobe high in cycles 2..1+StrobeLen; in_ready=1 again at cycle 3+StrobeLen.
//    Max throughput is 1 word per 3+StrobeLen cycles.
//  - All outputs are registered; FrameStrobe never has more than one bit high at any time.
//  - err and clear_err: clear_err has priority over a same-cycle error set. err is 0 the cycle after clear_err.
//  - in_valid while busy: ignored, not consumed; the source must hold the word until in_ready.
//  - Reset during STROBE: strobes drop asynchronously, the partial write is not counted, and the loader returns to IDLE.
// TESTING
//  1 Reset, then word row=1 frame=5 data=32'hDEADBEEF -> FrameData[63:32]=DEADBEEF from cycle 1.
//    FrameStrobe bit 25 high in cycle 2 only; in_ready back at cycle 4; frames_written=1.
//  2 Back-to-back valid words (row0 f0, row0 f19) -> second accepted at cycle 4; strobe bits 0 then 19.
//    Each is single-cycle and never simultaneous; frames_written=2.
//  3 Word row=2 (NumRows=2) or frame=20 -> err=1; no strobe; count unchanged; in_ready stays 1.
//    clear_err -> err=0 next cycle.
//  4 StrobeLen=3: word row0 f7 -> bit 7 high for cycles 2-4; in_ready at cycle 6.
//  5 Assert Reset in the STROBE cycle -> FrameStrobe=0 and FrameData=0 immediately; frames_written=0; in_ready=1 after release.
//  6 Preload frames_written to 16'hFFFE, then write 3 frames -> frames_written saturates at 16'hFFFF.

Source files
------------

// File: rtl/supertile_frame_loader.sv
// Frame-word loader for one supertile column: takes (row, frame, data) words and drives per-row FrameData
// with a one-hot FrameStrobe. A word is accepted in cycle 0, the strobe is high in cycles 2..1+StrobeLen,
// and the loader is ready again in cycle 3+StrobeLen; words offered while busy are not consumed.
module supertile_frame_loader #(
    parameter int          NumRows         = 2,
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter int          StrobeLen       = 1,
    parameter logic [15:0] CountInit       = 16'h0000,
    localparam int         RowW            = (NumRows > 1) ? $clog2(NumRows) : 1,
    localparam int         FrmW            = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                                   UserCLK,
    input  logic                                   Reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [RowW-1:0]                        in_row,
    input  logic [FrmW-1:0]                        in_frame,
    input  logic [FrameBitsPerRow-1:0]             in_data,
    input  logic                                   clear_err,
    output logic [NumRows*FrameBitsPerRow-1:0]     FrameData,
    output logic [NumRows*MaxFramesPerCol-1:0]     FrameStrobe,
    output logic                                   busy,
    output logic                                   err,
    output logic [15:0]                            frames_written
);

    localparam int CntW = (StrobeLen > 1) ? $clog2(StrobeLen) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t                                 state_q, state_d;
    logic [RowW-1:0]                        row_q, row_d;
    logic [FrmW-1:0]                        frame_q, frame_d;
    logic [CntW-1:0]                        cnt_q, cnt_d;
    logic [NumRows*FrameBitsPerRow-1:0]     data_q, data_d;
    logic [NumRows*MaxFramesPerCol-1:0]     strobe_q, strobe_d;
    logic                                   err_q, err_d;
    logic [15:0]                            fw_q, fw_d;
    logic                                   word_ok;

    assign word_ok = (int'(in_row) < NumRows) && (int'(in_frame) < MaxFramesPerCol);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        strobe_d = '0;
        err_d    = err_q;
        fw_d     = fw_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (word_ok) begin
                        row_d   = in_row;
                        frame_d = in_frame;
                        // Data is registered at acceptance so it is settled a full cycle before the strobe.
                        for (int r = 0; r < NumRows; r++) begin
                            if (int'(in_row) == r) data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = in_data;
                        end
                        state_d = SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CntW'(StrobeLen - 1);
            end
            STROBE: begin
                if (cnt_q == '0) state_d = HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            HOLD: begin
                state_d = IDLE;
                if (fw_q != 16'hFFFF) fw_d = fw_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase

        if (clear_err) err_d = 1'b0;

        // Strobe is a registered decode of the next state, so it can only ever have one bit set.
        if (state_d == STROBE) strobe_d[int'(row_q) * MaxFramesPerCol + int'(frame_q)] = 1'b1;
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            frame_q  <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            err_q    <= 1'b0;
            fw_q     <= CountInit;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            fw_q     <= fw_d;
        end
    end

    assign in_ready       = (state_q == IDLE) && !Reset;
    assign busy           = (state_q != IDLE);
    assign FrameData      = data_q;
    assign FrameStrobe    = strobe_q;
    assign err            = err_q;
    assign frames_written = fw_q;

endmodule

// File: tb/tb_supertile_frame_loader.sv
// Directed bench: instance a (StrobeLen=1) covers basic writes, back-to-back, errors and reset mid-strobe;
// instance b (StrobeLen=3, counter preset near saturation) covers long strobes and count saturation.
module tb_supertile_frame_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // instance a
    logic        a_rst, a_valid, a_ready, a_clear, a_busy, a_err;
    logic        a_row;
    logic [4:0]  a_frame;
    logic [31:0] a_data;
    logic [63:0] a_fd;
    logic [39:0] a_fs;
    logic [15:0] a_fw;

    // instance b
    logic        b_rst, b_valid, b_ready, b_clear, b_busy, b_err;
    logic        b_row;
    logic [4:0]  b_frame;
    logic [31:0] b_data;
    logic [63:0] b_fd;
    logic [39:0] b_fs;
    logic [15:0] b_fw;

    supertile_frame_loader #(.StrobeLen(1)) dut_a (
        .UserCLK(clk), .Reset(a_rst), .in_valid(a_valid), .in_ready(a_ready),
        .in_row(a_row), .in_frame(a_frame), .in_data(a_data), .clear_err(a_clear),
        .FrameData(a_fd), .FrameStrobe(a_fs), .busy(a_busy), .err(a_err), .frames_written(a_fw)
    );

    supertile_frame_loader #(.StrobeLen(3), .CountInit(16'hFFFE)) dut_b (
        .UserCLK(clk), .Reset(b_rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_row(b_row), .in_frame(b_frame), .in_data(b_data), .clear_err(b_clear),
        .FrameData(b_fd), .FrameStrobe(b_fs), .busy(b_busy), .err(b_err), .frames_written(b_fw)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_clear = 1'b0; a_row = 1'b0; a_frame = '0; a_data = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_clear = 1'b0; b_row = 1'b0; b_frame = '0; b_data = '0;
        #1;
        check_eq("rst_fd", a_fd, 64'h0);
        check_eq("rst_fs", a_fs, 64'h0);
        check_eq("rst_err", a_err, 0);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_fw", a_fw, 0);
        tick(); tick();
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
        check_eq("rst_ready", a_ready, 1);

        // single word row1 frame5 -> strobe bit 20+5
        a_valid = 1'b1; a_row = 1'b1; a_frame = 5'd5; a_data = 32'hDEADBEEF;
        tick();                                                   // cycle 1
        a_valid = 1'b0;
        check_eq("t1_fd_c1", a_fd, 64'hDEADBEEF_00000000);
        check_eq("t1_fs_c1", a_fs, 64'h0);
        check_eq("t1_busy_c1", a_busy, 1);
        tick();                                                   // cycle 2
        check_eq("t1_fs_c2", a_fs, 64'd1 << 25);
        tick();                                                   // cycle 3
        check_eq("t1_fs_c3", a_fs, 64'h0);
        check_eq("t1_rdy_c3", a_ready, 0);
        tick();                                                   // cycle 4
        check_eq("t1_rdy_c4", a_ready, 1);
        check_eq("t1_fw", a_fw, 1);

        // back-to-back: second word held through the busy window
        a_valid = 1'b1; a_row = 1'b0; a_frame = 5'd0; a_data = 32'hAAAA0001;
        tick();                                                   // cycle 1
        a_frame = 5'd19; a_data = 32'h5555AAAA;
        check_eq("t2_rdy_c1", a_ready, 0);
        check_eq("t2_fd_c1", a_fd, 64'hDEADBEEF_AAAA0001);
        check_eq("t2_fs_c1", a_fs, 64'h0);
        tick();                                                   // cycle 2
        check_eq("t2_fs_c2", a_fs, 64'd1);
        tick();                                                   // cycle 3
        check_eq("t2_fs_c3", a_fs, 64'h0);
        check_eq("t2_fd_c3", a_fd, 64'hDEADBEEF_AAAA0001);
        tick();                                                   // cycle 4: second word accepted
        check_eq("t2_rdy_c4", a_ready, 1);
        check_eq("t2_fs_c4", a_fs, 64'h0);
        tick();                                                   // cycle 5
        a_valid = 1'b0;
        check_eq("t2_fd_c5", a_fd, 64'hDEADBEEF_5555AAAA);
        check_eq("t2_fs_c5", a_fs, 64'h0);
        tick();                                                   // cycle 6
        check_eq("t2_fs_c6", a_fs, 64'd1 << 19);
        tick();                                                   // cycle 7
        check_eq("t2_fs_c7", a_fs, 64'h0);
        tick();                                                   // cycle 8
        check_eq("t2_rdy_c8", a_ready, 1);
        check_eq("t2_fw", a_fw, 3);

        // out-of-range frame is consumed and flagged
        a_valid = 1'b1; a_row = 1'b0; a_frame = 5'd20; a_data = 32'h11111111;
        tick();
        a_valid = 1'b0;
        check_eq("t3_err", a_err, 1);
        check_eq("t3_rdy", a_ready, 1);
        check_eq("t3_busy", a_busy, 0);
        check_eq("t3_fs", a_fs, 64'h0);
        check_eq("t3_fw", a_fw, 3);
        check_eq("t3_fd", a_fd, 64'hDEADBEEF_5555AAAA);
        // clear wins over a simultaneous new error
        a_valid = 1'b1; a_frame = 5'd31; a_clear = 1'b1;
        tick();
        a_valid = 1'b0; a_clear = 1'b0;
        check_eq("t3_clr_prio", a_err, 0);
        tick();
        check_eq("t3_clr_hold", a_err, 0);
        check_eq("t3_fs_none", a_fs, 64'h0);

        // reset asserted while strobing
        a_valid = 1'b1; a_row = 1'b1; a_frame = 5'd3; a_data = 32'h12345678;
        tick();
        a_valid = 1'b0;
        tick();
        check_eq("t5_fs_c2", a_fs, 64'd1 << 23);
        #2 a_rst = 1'b1;
        #1;
        check_eq("t5_fs_rst", a_fs, 64'h0);
        check_eq("t5_fd_rst", a_fd, 64'h0);
        check_eq("t5_fw_rst", a_fw, 0);
        check_eq("t5_rdy_rst", a_ready, 0);
        @(negedge clk);
        a_rst = 1'b0;
        tick();
        check_eq("t5_rdy_rel", a_ready, 1);
        check_eq("t5_busy_rel", a_busy, 0);
        check_eq("t5_fw_rel", a_fw, 0);

        // StrobeLen=3 instance, counter preset to FFFE
        check_eq("t6_fw_init", b_fw, 16'hFFFE);
        b_valid = 1'b1; b_row = 1'b0; b_frame = 5'd7; b_data = 32'hCAFEF00D;
        for (int c = 1; c <= 6; c++) begin
            tick();
            b_valid = 1'b0;
            check_eq($sformatf("t4_fs_c%0d", c), b_fs, (c >= 2 && c <= 4) ? (64'd1 << 7) : 64'h0);
            check_eq($sformatf("t4_rdy_c%0d", c), b_ready, (c == 6) ? 1 : 0);
        end
        check_eq("t4_fd", b_fd, 64'h00000000_CAFEF00D);
        check_eq("t6_fw_1", b_fw, 16'hFFFF);
        for (int k = 0; k < 2; k++) begin
            int waited;
            b_valid = 1'b1; b_row = 1'(k == 0); b_frame = (k == 0) ? 5'd19 : 5'd0; b_data = 32'h0;
            tick();
            b_valid = 1'b0;
            waited = 0;
            while (!b_ready && waited < 20) begin
                tick();
                waited++;
            end
            check_eq($sformatf("t6_wait_%0d", k), b_ready, 1);
        end
        check_eq("t6_fw_sat", b_fw, 16'hFFFF);
        check_eq("t6_err", b_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
